fifo_writer_logic: RTL

FIFO_WRITER_LOGIC -- requirements
Module: fifo_writer_logic

---
 rtl/fifo_writer_logic_pkg.sv | 34 +++
 rtl/fifo_writer_logic.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fifo_writer_logic_pkg.sv
// Shared definitions for the FIFO PLB slave interfaces: chip-enable encodings,
// CTRL/STATUS bit positions, writer FSM states and a ceiling-log2 helper.
package fifo_writer_logic_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PUSH = 1'b1
    } wr_state_t;

    // Chip-enable encodings as seen on a two-register PLB slave
    localparam logic [1:0] CE_DATA = 2'b10;
    localparam logic [1:0] CE_CTRL = 2'b01;

    // CTRL bits numbered by value weight (bit 0 is PLB bit 31)
    localparam int CTRL_ABORT_BIT   = 0;
    localparam int CTRL_CLR_OVF_BIT = 1;

    localparam int STAT_FULL_BIT     = 0;
    localparam int STAT_PENDING_BIT  = 1;
    localparam int STAT_OVERFLOW_BIT = 2;
    localparam int STAT_IDX_LSB      = 3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_writer_logic.sv
// PLB slave that assembles several bus writes into one FIFO word and pushes it
// when the FIFO has room; CTRL register aborts/clears overflow, STATUS reports progress.
module fifo_writer_logic
    import fifo_writer_logic_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int PLB_DATA_WIDTH = 32,
    parameter int PLB_REG_COUNT  = 2
) (
    input  logic                        iPlbClk,
    input  logic                        iPlbResetN,
    output logic [DATA_WIDTH-1:0]       oData,
    output logic                        oWriteEn,
    input  logic                        iFull,
    input  logic [0:PLB_DATA_WIDTH-1]   iPlbData,
    input  logic [0:PLB_DATA_WIDTH/8-1] iPlbBE,
    input  logic [0:PLB_REG_COUNT-1]    iPlbRdCE,
    input  logic [0:PLB_REG_COUNT-1]    iPlbWrCE,
    output logic [0:PLB_DATA_WIDTH-1]   oPlbData,
    output logic                        oPlbRdAck,
    output logic                        oPlbWrAck,
    output logic                        oPlbError
);

    localparam int PLB_WRITES_COUNT = (DATA_WIDTH - 1) / PLB_DATA_WIDTH + 1;
    localparam int IDX_WIDTH        = clog2(PLB_WRITES_COUNT) + 1;
    localparam int ASM_WIDTH        = PLB_WRITES_COUNT * PLB_DATA_WIDTH;
    localparam int STATUS_WIDTH     = STAT_IDX_LSB + IDX_WIDTH;

    localparam logic [IDX_WIDTH-1:0]     LAST_IDX = IDX_WIDTH'(PLB_WRITES_COUNT - 1);
    localparam logic [PLB_REG_COUNT-1:0] SEL_DATA = PLB_REG_COUNT'(CE_DATA);
    localparam logic [PLB_REG_COUNT-1:0] SEL_CTRL = PLB_REG_COUNT'(CE_CTRL);

    wr_state_t                 state_reg, state_next;
    logic [IDX_WIDTH-1:0]      idx_reg, idx_next;
    logic [ASM_WIDTH-1:0]      asm_reg, asm_next;
    logic                      overflow_reg, overflow_next;
    logic                      new_write_reg, new_write_next;

    // Value-weighted views of the big-endian PLB vectors
    logic [PLB_DATA_WIDTH-1:0] plb_wdata;
    logic [PLB_REG_COUNT-1:0]  wr_ce;
    logic [PLB_REG_COUNT-1:0]  rd_ce;
    logic [PLB_DATA_WIDTH-1:0] rd_data;
    logic [STATUS_WIDTH-1:0]   status_word;
    logic                      data_wr;
    logic                      ctrl_wr;
    logic                      write_en;
    logic                      unused_bits;

    assign plb_wdata = iPlbData;
    assign wr_ce     = iPlbWrCE;
    assign rd_ce     = iPlbRdCE;

    assign oPlbWrAck = |iPlbWrCE;
    assign oPlbRdAck = |iPlbRdCE;
    assign oPlbError = 1'b0;

    // Act only on the first cycle of each write chip-enable assertion
    assign data_wr  = new_write_reg && (wr_ce == SEL_DATA);
    assign ctrl_wr  = new_write_reg && (wr_ce == SEL_CTRL);
    assign write_en = (state_reg == ST_PUSH) && !iFull;

    assign oWriteEn = write_en;
    assign oData    = asm_reg[DATA_WIDTH-1:0];

    generate
        if (ASM_WIDTH > DATA_WIDTH) begin : g_excess
            assign unused_bits = ^{iPlbBE, asm_reg[ASM_WIDTH-1:DATA_WIDTH]};
        end else begin : g_no_excess
            assign unused_bits = ^iPlbBE;
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        asm_next       = asm_reg;
        overflow_next  = overflow_reg;
        new_write_next = !(|wr_ce);

        case (state_reg)
            ST_IDLE: begin
                if (data_wr) begin
                    asm_next = (asm_reg << PLB_DATA_WIDTH) | ASM_WIDTH'(plb_wdata);
                    if (idx_reg == LAST_IDX) begin
                        idx_next   = '0;
                        state_next = ST_PUSH;
                    end else begin
                        idx_next = idx_reg + IDX_WIDTH'(1);
                    end
                end
            end
            ST_PUSH: begin
                if (write_en) begin
                    state_next = ST_IDLE;
                end
                // The held word must not move, so a write here is only recorded
                if (data_wr) begin
                    overflow_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // An abort coinciding with a push still lets that push complete this edge
        if (ctrl_wr) begin
            if (plb_wdata[CTRL_CLR_OVF_BIT]) begin
                overflow_next = 1'b0;
            end
            if (plb_wdata[CTRL_ABORT_BIT]) begin
                idx_next   = '0;
                asm_next   = '0;
                state_next = ST_IDLE;
            end
        end
    end

    always_ff @(posedge iPlbClk or negedge iPlbResetN) begin
        if (!iPlbResetN) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            asm_reg       <= '0;
            overflow_reg  <= 1'b0;
            new_write_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            asm_reg       <= asm_next;
            overflow_reg  <= overflow_next;
            new_write_reg <= new_write_next;
        end
    end

    always_comb begin
        status_word                                  = '0;
        status_word[STAT_FULL_BIT]                   = iFull;
        status_word[STAT_PENDING_BIT]                = (state_reg == ST_PUSH);
        status_word[STAT_OVERFLOW_BIT]               = overflow_reg;
        status_word[STAT_IDX_LSB +: IDX_WIDTH]       = idx_reg;
    end

    // DATA reads and unrecognised chip-enables read back as zero
    always_comb begin
        rd_data = '0;
        if (rd_ce == SEL_CTRL) begin
            rd_data = PLB_DATA_WIDTH'(status_word);
        end
    end

    assign oPlbData = rd_data;

endmodule
